data_memory: RTL and testbench



---
 rtl/cpu_pkg.sv | 16 +
 rtl/data_memory_if.sv | 12 +
 rtl/data_memory_array.sv | 35 +++
 rtl/data_memory.sv | 58 +++++
 tb/tb_data_memory.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants used by the data memory and its neighbours.
package cpu_pkg;

  // Datapath word width.
  localparam int WORD_WIDTH = 32;

  // Default data memory geometry (words and index width).
  localparam int DMEM_RAM_SIZE     = 256;
  localparam int DMEM_RAM_SIZE_BIT = 8;

  // True when every bit of a high-address slice is clear.
  function automatic logic all_zero(input logic [WORD_WIDTH-1:0] v);
    return (v == {WORD_WIDTH{1'b0}});
  endfunction

endpackage

// File: rtl/data_memory_if.sv
// MEM-stage data bus: write enable, byte address, store data, load data.
interface data_memory_if;

  logic                            MemWrite;
  logic [cpu_pkg::WORD_WIDTH-1:0]  address;
  logic [cpu_pkg::WORD_WIDTH-1:0]  write_data;
  logic [cpu_pkg::WORD_WIDTH-1:0]  read_data;

  modport master (output MemWrite, output address, output write_data, input  read_data);
  modport slave  (input  MemWrite, input  address, input  write_data, output read_data);

endinterface

// File: rtl/data_memory_array.sv
// Word storage: asynchronous clear, one synchronous write port, one
// combinational read port.
module data_memory_array
  import cpu_pkg::*;
#(
  parameter int DEPTH = DMEM_RAM_SIZE,
  parameter int IDX_W = DMEM_RAM_SIZE_BIT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_we,
  input  logic [IDX_W-1:0]      i_idx,
  input  logic [WORD_WIDTH-1:0] i_wdata,
  output logic [WORD_WIDTH-1:0] o_rdata
);

  logic [WORD_WIDTH-1:0] r_mem [DEPTH];

  // Clear every word while reset is low; otherwise store on enabled edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 32'h0000_0000;
      end
    end else if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  // Same-cycle read of the addressed word.
  always_comb begin
    o_rdata = r_mem[i_idx];
  end

endmodule

// File: rtl/data_memory.sv
// Data RAM for the MEM stage: decodes the ALU byte address into a word
// index, drops out-of-range accesses and returns zero for them on reads.
module data_memory
  import cpu_pkg::*;
#(
  parameter int RAM_SIZE     = DMEM_RAM_SIZE,
  parameter int RAM_SIZE_BIT = DMEM_RAM_SIZE_BIT
) (
  input  logic          clk,
  input  logic          reset_n,
  data_memory_if.slave  bus
);

  logic [RAM_SIZE_BIT-1:0] w_idx;
  logic [WORD_WIDTH-1:0]   w_hi;
  logic                    w_in_range;
  logic                    w_we;
  logic [WORD_WIDTH-1:0]   w_arr_rdata;
  logic [WORD_WIDTH-1:0]   w_rdata;
  logic                    w_unused_lsbs;

  // Byte-lane bits select within a word and play no part in addressing.
  assign w_unused_lsbs = &{1'b0, bus.address[1:0]};

  // Word index and range check; bits above the index must all be zero.
  always_comb begin
    w_idx      = bus.address[RAM_SIZE_BIT+1:2];
    w_hi       = {WORD_WIDTH{1'b0}};
    w_hi[WORD_WIDTH-RAM_SIZE_BIT-3:0] = bus.address[WORD_WIDTH-1:RAM_SIZE_BIT+2];
    w_in_range = all_zero(w_hi);
    w_we       = bus.MemWrite & w_in_range;
  end

  data_memory_array #(
    .DEPTH (RAM_SIZE),
    .IDX_W (RAM_SIZE_BIT)
  ) u_array (
    .clk     (clk),
    .reset_n (reset_n),
    .i_we    (w_we),
    .i_idx   (w_idx),
    .i_wdata (bus.write_data),
    .o_rdata (w_arr_rdata)
  );

  // Out-of-range reads return zero instead of an aliased word.
  always_comb begin
    w_rdata = 32'h0000_0000;
    if (w_in_range) begin
      w_rdata = w_arr_rdata;
    end else begin
      w_rdata = 32'h0000_0000;
    end
  end

  assign bus.read_data = w_rdata;

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: stimulus pushes expected read words,
// a monitor samples read_data on each sample request and compares.
module tb_data_memory;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;
  exp_t sb_q[$];
  event sample_ev;

  data_memory_if bus();

  data_memory dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: on each sample request pop the oldest expectation and compare.
  initial begin
    n_tests = 0;
    n_fail  = 0;
    forever begin
      @(sample_ev);
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_underflow: got %08h with no expectation queued", bus.read_data);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        n_tests++;
        if (bus.read_data !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got %08h expected %08h", e.name, bus.read_data, e.exp);
        end
      end
    end
  end

  // Present an address, queue the expected word, then request a sample.
  task automatic check(input logic [31:0] addr, input logic [31:0] exp, input string name);
    exp_t e;
    bus.address = addr;
    #1;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
    -> sample_ev;
    #1;
  endtask

  // Drive one write at a falling edge; it lands on the following rising edge.
  task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.MemWrite   = 1'b1;
    bus.address    = addr;
    bus.write_data = data;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.MemWrite = 1'b0;
  endtask

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_cnt;
    reset_n        = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.address    = 32'h0;
    bus.write_data = 32'h0;
    repeat (2) @(negedge clk);
    check(32'h0000_0000, 32'h0000_0000, "in_reset_0x0");
    reset_n = 1'b1;
    @(negedge clk);

    // Post-reset contents are zero.
    check(32'h0000_0000, 32'h0000_0000, "reset_0x0");
    check(32'h0000_0004, 32'h0000_0000, "reset_0x4");
    check(32'h0000_03FC, 32'h0000_0000, "reset_0x3FC");

    // Back-to-back writes on consecutive edges.
    write_word(32'h0000_0004, 32'h1111_1111);
    write_word(32'h0000_0008, 32'h2222_2222);
    idle();
    check(32'h0000_0004, 32'h1111_1111, "rd_0x4");
    check(32'h0000_0008, 32'h2222_2222, "rd_0x8");
    check(32'h0000_0004, 32'h1111_1111, "rd_0x4_again");

    // Read during write: old word before the edge, new word after.
    write_word(32'h0000_0010, 32'hDEAD_BEEF);
    check(32'h0000_0010, 32'h0000_0000, "rdw_before");
    @(posedge clk);
    #1;
    check(32'h0000_0010, 32'hDEAD_BEEF, "rdw_after");
    idle();

    // Misaligned write hits the containing word.
    write_word(32'h0000_0007, 32'hCAFE_F00D);
    idle();
    check(32'h0000_0004, 32'hCAFE_F00D, "misalign_0x4");
    check(32'h0000_0006, 32'hCAFE_F00D, "misalign_0x6");

    // Out-of-range write is dropped without aliasing onto word 0.
    write_word(32'h0000_0400, 32'h0000_0005);
    idle();
    check(32'h0000_0400, 32'h0000_0000, "oor_0x400");
    check(32'h0000_0000, 32'h0000_0000, "oor_alias_0x0");
    check(32'h8000_0004, 32'h0000_0000, "oor_hi_bit");
    check(32'h0000_0008, 32'h2222_2222, "oor_keep_0x8");

    // Disabled write over three edges leaves the word intact.
    @(negedge clk);
    bus.MemWrite   = 1'b0;
    bus.address    = 32'h0000_0004;
    bus.write_data = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    check(32'h0000_0004, 32'hCAFE_F00D, "we0_keep_0x4");

    // Asynchronous reset between edges, with a write attempted during it.
    @(negedge clk);
    #2;
    bus.address = 32'h0000_0004;
    reset_n     = 1'b0;
    check(32'h0000_0004, 32'h0000_0000, "async_rst_0x4");
    bus.MemWrite   = 1'b1;
    bus.address    = 32'h0000_0008;
    bus.write_data = 32'h3333_3333;
    @(posedge clk);
    @(negedge clk);
    bus.MemWrite = 1'b0;
    reset_n      = 1'b1;
    check(32'h0000_0008, 32'h0000_0000, "rst_blocked_wr");
    check(32'h0000_0010, 32'h0000_0000, "rst_cleared_0x10");

    // First write after release takes effect.
    write_word(32'h0000_000C, 32'hA5A5_A5A5);
    idle();
    check(32'h0000_000C, 32'hA5A5_A5A5, "post_rst_wr");

    // Drain the scoreboard with a bounded wait.
    wait_cnt = 0;
    while (sb_q.size() != 0 && wait_cnt < 100) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
